// File: rtl/arbitro_escritura_banco.sv
// Round-robin arbiter for the banco_registros write port between the ALU (req 0) and load (req 1) paths.
// Registered output stage with 1-cycle latency; ready is combinational and withheld under stall or reset.
module arbitro_escritura_banco #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              stall,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_reg,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_reg,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic [ADDR_W-1:0] writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic              RegWrite,
   output logic              grant_id,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   output logic              hazard1,
   output logic              hazard2
);

   logic              gnt0, gnt1;
   logic              prio_q, prio_d;
   logic              regwrite_q, regwrite_d;
   logic              grant_id_q, grant_id_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   // prio_q = 0 means requester 0 wins a tie.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!RST && !stall) begin
         gnt0 = req0_valid && (!req1_valid || !prio_q);
         gnt1 = req1_valid && (!req0_valid ||  prio_q);
      end
   end

   always_comb begin
      prio_d       = prio_q;
      regwrite_d   = 1'b0;
      grant_id_d   = grant_id_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (gnt0) begin
         prio_d       = 1'b1;
         regwrite_d   = |req0_reg;
         grant_id_d   = 1'b0;
         write_reg_d  = req0_reg;
         write_data_d = req0_data;
      end else if (gnt1) begin
         prio_d       = 1'b0;
         regwrite_d   = |req1_reg;
         grant_id_d   = 1'b1;
         write_reg_d  = req1_reg;
         write_data_d = req1_data;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prio_q       <= 1'b0;
         regwrite_q   <= 1'b0;
         grant_id_q   <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         prio_q       <= prio_d;
         regwrite_q   <= regwrite_d;
         grant_id_q   <= grant_id_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign writeReg   = write_reg_q;
   assign writeData  = write_data_q;
   assign RegWrite   = regwrite_q;
   assign grant_id   = grant_id_q;

   // A read is stale if any not-yet-committed write (pending or in the output stage) targets it.
   assign hazard1 = (|readReg1) &&
                    ((req0_valid && (readReg1 == req0_reg)) ||
                     (req1_valid && (readReg1 == req1_reg)) ||
                     (regwrite_q && (readReg1 == write_reg_q)));
   assign hazard2 = (|readReg2) &&
                    ((req0_valid && (readReg2 == req0_reg)) ||
                     (req1_valid && (readReg2 == req1_reg)) ||
                     (regwrite_q && (readReg2 == write_reg_q)));

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Directed bench for arbitro_escritura_banco: inputs driven at negedge, outputs sampled mid-cycle or #1 after posedge.
module tb_arbitro_escritura_banco;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              CLK = 1'b0;
   logic              RST;
   logic              stall;
   logic              req0_valid, req1_valid;
   logic [ADDR_W-1:0] req0_reg, req1_reg;
   logic [DATA_W-1:0] req0_data, req1_data;
   logic              req0_ready, req1_ready;
   logic [ADDR_W-1:0] writeReg;
   logic [DATA_W-1:0] writeData;
   logic              RegWrite, grant_id;
   logic [ADDR_W-1:0] readReg1, readReg2;
   logic              hazard1, hazard2;

   int checks   = 0;
   int failures = 0;

   arbitro_escritura_banco #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RST(RST), .stall(stall),
      .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
      .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite), .grant_id(grant_id),
      .readReg1(readReg1), .readReg2(readReg2), .hazard1(hazard1), .hazard2(hazard2)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      RST = 1'b1; stall = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_reg = '0; req1_reg = '0; req0_data = '0; req1_data = '0;
      readReg1 = '0; readReg2 = '0;
      @(posedge CLK); @(posedge CLK); #1;
      checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
      checks++; if (writeReg !== 5'd0) begin failures++; $display("FAIL reset_writereg got=%0d exp=0", writeReg); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
      checks++; if ({hazard1, hazard2} !== 2'b00) begin failures++; $display("FAIL reset_hazard got=%b exp=00", {hazard1, hazard2}); end
      req0_valid = 1'b1; req1_valid = 1'b1; #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready_valid got=%b exp=00", {req0_ready, req1_ready}); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge CLK); RST = 1'b0;
   endtask

   task automatic test_contention();
      logic [DATA_W-1:0] d0, d1;
      int exp_id;
      d0 = 32'h0000_0100; d1 = 32'h0000_0200;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         req0_valid = 1'b1; req0_reg = 5'd3; req0_data = d0;
         req1_valid = 1'b1; req1_reg = 5'd7; req1_data = d1;
         exp_id = i % 2;
         #1;
         checks++; if ({req1_ready, req0_ready} !== (exp_id == 1 ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL contention_ready[%0d] got=%b exp_id=%0d", i, {req1_ready, req0_ready}, exp_id); end
         @(posedge CLK); #1;
         checks++; if (grant_id !== exp_id[0] || RegWrite !== 1'b1) begin
            failures++; $display("FAIL contention_grant[%0d] got id=%b rw=%b exp id=%0d rw=1", i, grant_id, RegWrite, exp_id); end
         checks++; if (writeReg !== (exp_id == 1 ? 5'd7 : 5'd3) || writeData !== (exp_id == 1 ? d1 : d0)) begin
            failures++; $display("FAIL contention_out[%0d] got reg=%0d data=%h", i, writeReg, writeData); end
         if (exp_id == 1) d1 = d1 + 1; else d0 = d0 + 1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_single();
      @(negedge CLK);
      req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'h0000_00A1;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
      @(posedge CLK); #1;
      req0_valid = 1'b0; readReg1 = 5'd5; #1;
      checks++; if (RegWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'h0000_00A1 || grant_id !== 1'b0) begin
         failures++; $display("FAIL single_out got rw=%b reg=%0d data=%h id=%b exp rw=1 reg=5 data=000000a1 id=0", RegWrite, writeReg, writeData, grant_id); end
      checks++; if (hazard1 !== 1'b1) begin failures++; $display("FAIL single_hazard_stage got=%b exp=1", hazard1); end
      @(posedge CLK); #1;
      checks++; if (RegWrite !== 1'b0 || writeReg !== 5'd5 || writeData !== 32'h0000_00A1) begin
         failures++; $display("FAIL single_hold got rw=%b reg=%0d data=%h exp rw=0 reg=5 data=000000a1", RegWrite, writeReg, writeData); end
      checks++; if (hazard1 !== 1'b0) begin failures++; $display("FAIL single_hazard_clear got=%b exp=0", hazard1); end
      readReg1 = '0;
   endtask

   task automatic test_x0_discard();
      @(negedge CLK);
      req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hFFFF_FFFF; readReg1 = 5'd0;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b01 || hazard1 !== 1'b0) begin
         failures++; $display("FAIL x0_ready got rdy=%b hz1=%b exp rdy=01 hz1=0", {req0_ready, req1_ready}, hazard1); end
      @(posedge CLK); #1;
      req1_valid = 1'b0;
      checks++; if (RegWrite !== 1'b0 || grant_id !== 1'b1 || hazard1 !== 1'b0) begin
         failures++; $display("FAIL x0_out got rw=%b id=%b hz1=%b exp rw=0 id=1 hz1=0", RegWrite, grant_id, hazard1); end
   endtask

   task automatic test_stall_hazard();
      @(negedge CLK);
      stall = 1'b1; req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'h0000_0099; readReg2 = 5'd9;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({req0_ready, req1_ready} !== 2'b00 || hazard2 !== 1'b1) begin
            failures++; $display("FAIL stall_hold[%0d] got rdy=%b hz2=%b exp rdy=00 hz2=1", i, {req0_ready, req1_ready}, hazard2); end
         @(posedge CLK); #1;
         checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL stall_rw[%0d] got=%b exp=0", i, RegWrite); end
         @(negedge CLK);
      end
      stall = 1'b0; #1;
      checks++; if (req0_ready !== 1'b1 || hazard2 !== 1'b1) begin
         failures++; $display("FAIL stall_release got rdy0=%b hz2=%b exp 1 1", req0_ready, hazard2); end
      @(posedge CLK); #1;
      req0_valid = 1'b0; stall = 1'b1; #1;
      checks++; if (RegWrite !== 1'b1 || writeReg !== 5'd9 || hazard2 !== 1'b1) begin
         failures++; $display("FAIL stall_complete got rw=%b reg=%0d hz2=%b exp rw=1 reg=9 hz2=1", RegWrite, writeReg, hazard2); end
      @(posedge CLK); #1;
      checks++; if (hazard2 !== 1'b0 || RegWrite !== 1'b0) begin
         failures++; $display("FAIL stall_hazard_clear got hz2=%b rw=%b exp 0 0", hazard2, RegWrite); end
      stall = 1'b0; readReg2 = '0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         req0_valid = 1'b1; req0_reg = 5'(10 + i); req0_data = 32'hB000_0000 + i;
         @(posedge CLK); #1;
         checks++; if (RegWrite !== 1'b1 || writeReg !== 5'(10 + i) || writeData !== 32'hB000_0000 + i) begin
            failures++; $display("FAIL b2b[%0d] got rw=%b reg=%0d data=%h", i, RegWrite, writeReg, writeData); end
      end
      req0_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge CLK);
      req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 32'h0000_0044;
      @(posedge CLK); #1;
      req0_valid = 1'b0;
      checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", RegWrite); end
      #1 RST = 1'b1; #1;
      checks++; if (RegWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0) begin
         failures++; $display("FAIL arst_clear got rw=%b reg=%0d data=%h exp 0 0 0", RegWrite, writeReg, writeData); end
      @(negedge CLK); RST = 1'b0;
      req0_valid = 1'b1; req0_reg = 5'd1; req1_valid = 1'b1; req1_reg = 5'd2;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++; $display("FAIL arst_prio got=%b exp=10", {req0_ready, req1_ready}); end
      @(posedge CLK); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_x0_discard();
      test_stall_hazard();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
